// File: rtl/ara_pkg.sv
// Shared constants and burst descriptor type for the global load/store AXI path.
package ara_pkg;

  localparam int unsigned PageBytes     = 4096;
  localparam int unsigned PageOffWidth  = 12;
  localparam int unsigned AxiMaxBeats   = 256;
  localparam int unsigned DescAddrWidth = 64;
  localparam int unsigned AxiLenWidth   = 8;

  typedef struct packed {
    logic [DescAddrWidth-1:0] addr;
    logic [AxiLenWidth-1:0]   len;
    logic                     store;
    logic                     last;
  } burst_desc_t;

endpackage

// File: rtl/global_ldst_burst_calc.sv
// Combinational burst sizing: clips the remaining bytes to the 4 KiB page and the
// beat cap, and derives the AXI len covering the (possibly unaligned) chunk.
module global_ldst_burst_calc
  import ara_pkg::*;
#(
  parameter int unsigned ByteCntWidth = 32,
  parameter int unsigned BeatBytes    = 64,
  parameter int unsigned MaxAxiBurst  = AxiMaxBeats
) (
  input  logic [PageOffWidth-1:0] page_off,
  input  logic [ByteCntWidth-1:0] remaining,
  output logic [ByteCntWidth-1:0] chunk,
  output logic [AxiLenWidth-1:0]  len,
  output logic                    last
);

  localparam int unsigned CalcWidth = ByteCntWidth + 1;
  localparam int unsigned OffWidth  = $clog2(BeatBytes);

  logic [CalcWidth-1:0] off;
  logic [CalcWidth-1:0] to_page;
  logic [CalcWidth-1:0] to_cap;
  logic [CalcWidth-1:0] rem_ext;
  logic [CalcWidth-1:0] chunk_ext;
  logic [CalcWidth-1:0] beats;

  always_comb begin
    off       = CalcWidth'(page_off[OffWidth-1:0]);
    to_page   = CalcWidth'(PageBytes) - CalcWidth'(page_off);
    to_cap    = CalcWidth'(MaxAxiBurst * BeatBytes) - off;
    rem_ext   = CalcWidth'(remaining);
    chunk_ext = rem_ext;
    if (to_page < chunk_ext) chunk_ext = to_page;
    if (to_cap < chunk_ext)  chunk_ext = to_cap;
    // Beats touched by [off, off+chunk), rounded up to whole beats.
    beats     = (off + chunk_ext + CalcWidth'(BeatBytes - 1)) >> OffWidth;
    chunk     = ByteCntWidth'(chunk_ext);
    len       = AxiLenWidth'(beats - CalcWidth'(1));
    last      = (chunk_ext == rem_ext);
  end

endmodule

// File: rtl/global_ldst_burst_sched.sv
// Splits one vector memory request into page- and beat-cap-bounded AXI INCR bursts,
// limits outstanding bursts, and pulses done once every burst has completed.
module global_ldst_burst_sched
  import ara_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 512,
  parameter int unsigned ByteCntWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MaxAxiBurst    = AxiMaxBeats
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [ByteCntWidth-1:0] req_bytes_i,
  input  logic                    req_store_i,
  output logic                    burst_valid_o,
  input  logic                    burst_ready_i,
  output logic [AxiAddrWidth-1:0] burst_addr_o,
  output logic [7:0]              burst_len_o,
  output logic                    burst_store_o,
  output logic                    burst_last_o,
  input  logic                    rsp_done_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [ByteCntWidth-1:0] rem_q, rem_d;
  logic                    store_q, store_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;

  logic [ByteCntWidth-1:0] chunk;
  logic [AxiLenWidth-1:0]  len;
  logic                    last;
  logic                    issue_hs;
  logic                    rsp_take;
  burst_desc_t             desc;

  global_ldst_burst_calc #(
    .ByteCntWidth(ByteCntWidth),
    .BeatBytes   (BeatBytes),
    .MaxAxiBurst (MaxAxiBurst)
  ) i_calc (
    .page_off (addr_q[PageOffWidth-1:0]),
    .remaining(rem_q),
    .chunk    (chunk),
    .len      (len),
    .last     (last)
  );

  // Next-state, datapath update and outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    store_d       = store_q;
    cnt_d         = cnt_q;
    desc          = '0;
    done_o        = 1'b0;
    req_ready_o   = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    burst_valid_o = (state_q == ISSUE) && (cnt_q != CntWidth'(MaxOutstanding));
    issue_hs      = burst_valid_o && burst_ready_i;
    rsp_take      = rsp_done_i && (cnt_q != '0);

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          rem_d   = req_bytes_i;
          store_d = req_store_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        desc.addr  = DescAddrWidth'(addr_q);
        desc.len   = len;
        desc.store = store_q;
        desc.last  = last;
        if (issue_hs) begin
          addr_d = addr_q + AxiAddrWidth'(chunk);
          rem_d  = rem_q - chunk;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response with nothing outstanding is dropped so the count never wraps.
    if (issue_hs && !rsp_take)      cnt_d = cnt_q + CntWidth'(1);
    else if (rsp_take && !issue_hs) cnt_d = cnt_q - CntWidth'(1);

    burst_addr_o  = AxiAddrWidth'(desc.addr);
    burst_len_o   = desc.len;
    burst_store_o = desc.store;
    burst_last_o  = desc.last;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      store_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_global_ldst_burst_sched.sv
// Directed bench: a 512-bit/4-credit scheduler and a 64-bit/2-credit scheduler,
// expected bursts queued at request time and popped on each handshake.
module tb_global_ldst_burst_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_store;
  logic [63:0] a_req_addr;
  logic [31:0] a_req_bytes;
  logic        a_bvalid, a_bready, a_bstore, a_blast, a_rsp, a_busy, a_done;
  logic [63:0] a_baddr;
  logic [7:0]  a_blen;

  logic        b_req_valid, b_req_ready, b_req_store;
  logic [63:0] b_req_addr;
  logic [31:0] b_req_bytes;
  logic        b_bvalid, b_bready, b_bstore, b_blast, b_rsp, b_busy, b_done;
  logic [63:0] b_baddr;
  logic [7:0]  b_blen;

  global_ldst_burst_sched #(
    .AxiAddrWidth(64), .AxiDataWidth(512), .ByteCntWidth(32), .MaxOutstanding(4), .MaxAxiBurst(256)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_bytes_i(a_req_bytes), .req_store_i(a_req_store),
    .burst_valid_o(a_bvalid), .burst_ready_i(a_bready), .burst_addr_o(a_baddr),
    .burst_len_o(a_blen), .burst_store_o(a_bstore), .burst_last_o(a_blast),
    .rsp_done_i(a_rsp), .busy_o(a_busy), .done_o(a_done)
  );

  global_ldst_burst_sched #(
    .AxiAddrWidth(64), .AxiDataWidth(64), .ByteCntWidth(32), .MaxOutstanding(2), .MaxAxiBurst(256)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_bytes_i(b_req_bytes), .req_store_i(b_req_store),
    .burst_valid_o(b_bvalid), .burst_ready_i(b_bready), .burst_addr_o(b_baddr),
    .burst_len_o(b_blen), .burst_store_o(b_bstore), .burst_last_o(b_blast),
    .rsp_done_i(b_rsp), .busy_o(b_busy), .done_o(b_done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic        store;
    logic        last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] addr, input logic [7:0] len,
                              input logic store, input logic last);
    exp_t e;
    e.addr = addr; e.len = len; e.store = store; e.last = last;
    return e;
  endfunction

  // Pop and compare on every handshake about to be taken at the next rising edge.
  task automatic mon();
    exp_t e;
    if (a_bvalid && a_bready) begin
      if (qa.size() == 0) chk("a_unexpected_burst", 64'(a_bvalid), 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_addr", a_baddr, e.addr);
        chk("a_len", 64'(a_blen), 64'(e.len));
        chk("a_last", 64'(a_blast), 64'(e.last));
        chk("a_store", 64'(a_bstore), 64'(e.store));
      end
    end
    if (b_bvalid && b_bready) begin
      if (qb.size() == 0) chk("b_unexpected_burst", 64'(b_bvalid), 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_addr", b_baddr, e.addr);
        chk("b_len", 64'(b_blen), 64'(e.len));
        chk("b_last", 64'(b_blast), 64'(e.last));
        chk("b_store", 64'(b_bstore), 64'(e.store));
      end
    end
  endtask

  task automatic cyc();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic req_a(input logic [63:0] addr, input logic [31:0] bytes, input logic store);
    a_req_addr = addr; a_req_bytes = bytes; a_req_store = store; a_req_valid = 1'b1;
    cyc();
    a_req_valid = 1'b0;
  endtask

  task automatic req_b(input logic [63:0] addr, input logic [31:0] bytes, input logic store);
    b_req_addr = addr; b_req_bytes = bytes; b_req_store = store; b_req_valid = 1'b1;
    cyc();
    b_req_valid = 1'b0;
  endtask

  task automatic finish_a(input string tag, input int budget);
    bit seen = 1'b0;
    a_bready = 1'b1; a_rsp = 1'b1;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (a_done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
    a_bready = 1'b0; a_rsp = 1'b0;
    cyc();
    chk({tag, "_idle"}, 64'(a_req_ready), 64'd1);
  endtask

  task automatic finish_b(input string tag, input int budget);
    bit seen = 1'b0;
    b_bready = 1'b1; b_rsp = 1'b1;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (b_done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
    b_bready = 1'b0; b_rsp = 1'b0;
    cyc();
    chk({tag, "_idle"}, 64'(b_req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_addr = '0; a_req_bytes = '0; a_req_store = 0; a_bready = 0; a_rsp = 0;
    b_req_valid = 0; b_req_addr = '0; b_req_bytes = '0; b_req_store = 0; b_bready = 0; b_rsp = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready", 64'(a_req_ready), 64'd1);
    chk("rst_valid", 64'(a_bvalid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_addr", a_baddr, 64'd0);
    chk("rst_len", 64'(a_blen), 64'd0);
    chk("rst_last", 64'(a_blast), 64'd0);
    chk("rst_store", 64'(a_bstore), 64'd0);
    chk("rst_b_valid", 64'(b_bvalid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single aligned burst, done one cycle after the response
    qa.push_back(mk(64'h1000, 8'd3, 1'b0, 1'b1));
    req_a(64'h1000, 32'd256, 1'b0);
    chk("t1_valid_next_cycle", 64'(a_bvalid), 64'd1);
    chk("t1_busy", 64'(a_busy), 64'd1);
    chk("t1_ready_low", 64'(a_req_ready), 64'd0);
    a_bready = 1'b1;
    cyc();
    a_bready = 1'b0;
    chk("t1_no_early_done", 64'(a_done), 64'd0);
    a_rsp = 1'b1;
    cyc();
    a_rsp = 1'b0;
    chk("t1_done_pulse", 64'(a_done), 64'd1);
    cyc();
    chk("t1_done_cleared", 64'(a_done), 64'd0);
    chk("t1_idle_ready", 64'(a_req_ready), 64'd1);
    chk("t1_idle_busy", 64'(a_busy), 64'd0);

    // Page split
    qa.push_back(mk(64'h1FC0, 8'd0, 1'b0, 1'b0));
    qa.push_back(mk(64'h2000, 8'd0, 1'b0, 1'b1));
    req_a(64'h1FC0, 32'd128, 1'b0);
    finish_a("t2_done", 20);

    // Unaligned start spanning two beats, store direction
    qa.push_back(mk(64'h1010, 8'd1, 1'b1, 1'b1));
    req_a(64'h1010, 32'd64, 1'b1);
    finish_a("t3_done", 20);

    // Beat cap on the 8-byte datapath
    qb.push_back(mk(64'h0, 8'd255, 1'b0, 1'b0));
    qb.push_back(mk(64'h800, 8'd255, 1'b0, 1'b1));
    req_b(64'h0, 32'd4096, 1'b0);
    finish_b("t4_done", 20);

    // Outstanding limit of two across three pages
    for (int i = 0; i < 6; i++) qb.push_back(mk(64'(i) * 64'h800, 8'd255, 1'b1, (i == 5)));
    req_b(64'h0, 32'd12288, 1'b1);
    b_bready = 1'b1;
    cyc();
    cyc();
    chk("t5_valid_capped", 64'(b_bvalid), 64'd0);
    cyc();
    chk("t5_still_capped", 64'(b_bvalid), 64'd0);
    chk("t5_queue_left", 64'(qb.size()), 64'd4);
    b_rsp = 1'b1;
    cyc();
    b_rsp = 1'b0;
    chk("t5_third_issues", 64'(b_bvalid), 64'd1);
    b_rsp = 1'b1;
    cyc();
    b_rsp = 1'b0;
    chk("t5_count_held", 64'(b_bvalid), 64'd1);
    cyc();
    chk("t5_capped_again", 64'(b_bvalid), 64'd0);
    chk("t5_queue_left2", 64'(qb.size()), 64'd2);
    finish_b("t5_done", 40);

    // Asynchronous reset in the middle of a request, then a clean restart
    qa.push_back(mk(64'hF00, 8'd3, 1'b0, 1'b0));
    req_a(64'hF00, 32'd1024, 1'b0);
    a_bready = 1'b1;
    cyc();
    a_bready = 1'b0;
    chk("t6_mid_valid", 64'(a_bvalid), 64'd1);
    chk("t6_mid_addr", a_baddr, 64'h1000);
    chk("t6_mid_len", 64'(a_blen), 64'd11);
    chk("t6_mid_last", 64'(a_blast), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(a_bvalid), 64'd0);
    chk("t6_rst_busy", 64'(a_busy), 64'd0);
    chk("t6_rst_ready", 64'(a_req_ready), 64'd1);
    chk("t6_rst_addr", a_baddr, 64'd0);
    chk("t6_rst_len", 64'(a_blen), 64'd0);
    chk("t6_rst_last", 64'(a_blast), 64'd0);
    chk("t6_rst_done", 64'(a_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    qa.push_back(mk(64'h2040, 8'd4, 1'b1, 1'b1));
    req_a(64'h2040, 32'd300, 1'b1);
    finish_a("t6_restart_done", 20);

    chk("end_qa_empty", 64'(qa.size()), 64'd0);
    chk("end_qb_empty", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
